// File: rtl/multi_lock_bank.sv
// multi_lock_bank: bank of power-on lock bits, unlocked by key through a 3-cycle request FSM.
// Optional feature macro MULTI_LOCK_STICKY_EN: a relocked channel refuses unlocks until reset.
module multi_lock_bank #(
    parameter int              NUM_CH     = 4,
    parameter int              KEY_W      = 16,
    parameter logic [KEY_W-1:0] UNLOCK_KEY = 16'hA5C3,
    parameter int              MAX_FAIL   = 3,
    localparam int             CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CH_W-1:0]   req_ch,
    input  logic              req_op,
    input  logic [KEY_W-1:0]  req_key,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [NUM_CH-1:0] locked,
    output logic [NUM_CH-1:0] lockout
);
    localparam int               CNT_W   = $clog2(MAX_FAIL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FAIL);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD     = 2'b01;
    localparam logic [1:0] ST_LOCKOUT = 2'b10;
    localparam logic [1:0] ST_DENY    = 2'b11;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
    state_t state, state_nxt;

    logic [CH_W-1:0]              ch_q;
    logic                         op_q;
    logic [KEY_W-1:0]             key_q;
    logic [NUM_CH-1:0][CNT_W-1:0] fail_cnt;

    // Outcome computed in CHECK for the addressed channel, committed in RESP
    logic             eval_wr, eval_locked, eval_lockout;
    logic [CNT_W-1:0] eval_cnt;
    logic [1:0]       eval_status;
    logic             pend_wr, pend_locked, pend_lockout;
    logic [CNT_W-1:0] pend_cnt;
    logic [1:0]       pend_status;
`ifdef MULTI_LOCK_STICKY_EN
    logic [NUM_CH-1:0] sticky;
    logic              eval_sticky, pend_sticky;
`endif

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) state_nxt = CHECK;
            end
            CHECK:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eval_wr      = 32'(ch_q) < NUM_CH;
        eval_locked  = locked[ch_q];
        eval_lockout = lockout[ch_q];
        eval_cnt     = fail_cnt[ch_q];
        eval_status  = ST_OK;
`ifdef MULTI_LOCK_STICKY_EN
        eval_sticky  = sticky[ch_q];
`endif
        if (!eval_wr) begin
            eval_status = ST_DENY;
        end else if (op_q) begin
            eval_locked = 1'b1;
`ifdef MULTI_LOCK_STICKY_EN
            eval_sticky = 1'b1;
`endif
        end
`ifdef MULTI_LOCK_STICKY_EN
        else if (sticky[ch_q]) begin
            eval_status = ST_DENY;
        end
`endif
        else if (lockout[ch_q]) begin
            eval_status = ST_LOCKOUT;
        end else if (key_q == UNLOCK_KEY) begin
            eval_locked = 1'b0;
            eval_cnt    = '0;
        end else begin
            eval_status = ST_BAD;
            if (fail_cnt[ch_q] < CNT_MAX) eval_cnt = fail_cnt[ch_q] + 1'b1;
            if (eval_cnt == CNT_MAX) begin
                eval_lockout = 1'b1;
                eval_locked  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ch_q         <= '0;
            op_q         <= 1'b0;
            key_q        <= '0;
            locked       <= '1;
            lockout      <= '0;
            fail_cnt     <= '0;
            rsp_valid    <= 1'b0;
            rsp_status   <= ST_OK;
            pend_wr      <= 1'b0;
            pend_locked  <= 1'b1;
            pend_lockout <= 1'b0;
            pend_cnt     <= '0;
            pend_status  <= ST_OK;
`ifdef MULTI_LOCK_STICKY_EN
            sticky       <= '0;
            pend_sticky  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ch_q  <= req_ch;
                        op_q  <= req_op;
                        key_q <= req_key;
                    end
                end
                CHECK: begin
                    pend_wr      <= eval_wr;
                    pend_locked  <= eval_locked;
                    pend_lockout <= eval_lockout;
                    pend_cnt     <= eval_cnt;
                    pend_status  <= eval_status;
`ifdef MULTI_LOCK_STICKY_EN
                    pend_sticky  <= eval_sticky;
`endif
                end
                RESP: begin
                    rsp_valid  <= 1'b1;
                    rsp_status <= pend_status;
                    key_q      <= '0;
                    if (pend_wr) begin
                        locked[ch_q]   <= pend_locked;
                        lockout[ch_q]  <= pend_lockout;
                        fail_cnt[ch_q] <= pend_cnt;
`ifdef MULTI_LOCK_STICKY_EN
                        sticky[ch_q]   <= pend_sticky;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_lock_bank.sv
// Scoreboard bench for multi_lock_bank: driver pushes model results, negedge monitor pops and compares.
module tb_multi_lock_bank;
    localparam logic [15:0] KEY      = 16'hA5C3;
    localparam int          MAX_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_op, rsp_valid;
    logic [1:0]  req_ch, rsp_status;
    logic [15:0] req_key;
    logic [3:0]  locked, lockout;

    logic        d3_valid, d3_ready, d3_op, d3_rsp_valid;
    logic [1:0]  d3_ch, d3_rsp_status;
    logic [15:0] d3_key;
    logic [2:0]  d3_locked, d3_lockout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [3:0] lk;
        logic [3:0] lo;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference state, kept as plain per-channel arrays
    logic [3:0] m_locked, m_lockout, m_sticky;
    int         m_fails[4];

    multi_lock_bank u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_op(req_op), .req_key(req_key), .rsp_valid(rsp_valid),
        .rsp_status(rsp_status), .locked(locked), .lockout(lockout)
    );

    multi_lock_bank #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(d3_valid), .req_ready(d3_ready),
        .req_ch(d3_ch), .req_op(d3_op), .req_key(d3_key), .rsp_valid(d3_rsp_valid),
        .rsp_status(d3_rsp_status), .locked(d3_locked), .lockout(d3_lockout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_locked  = '1;
        m_lockout = '0;
        m_sticky  = '0;
        for (int i = 0; i < 4; i++) m_fails[i] = 0;
    endtask

    task automatic model(input int ch, input bit op, input logic [15:0] key, output logic [1:0] st);
        if (ch >= 4) st = 2'd3;
        else if (op) begin
            m_locked[ch] = 1'b1;
            m_sticky[ch] = 1'b1;
            st = 2'd0;
        end
`ifdef MULTI_LOCK_STICKY_EN
        else if (m_sticky[ch]) st = 2'd3;
`endif
        else if (m_lockout[ch]) st = 2'd2;
        else if (key == KEY) begin
            m_locked[ch] = 1'b0;
            m_fails[ch]  = 0;
            st = 2'd0;
        end else begin
            st = 2'd1;
            m_fails[ch]++;
            if (m_fails[ch] >= MAX_FAIL) begin
                m_lockout[ch] = 1'b1;
                m_locked[ch]  = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_latency", cyc, mon_e.cyc);
                chk("rsp_status", 32'(rsp_status), 32'(mon_e.st));
                chk("locked", 32'(locked), 32'(mon_e.lk));
                chk("lockout", 32'(lockout), 32'(mon_e.lo));
            end
        end
    end

    // Issue one request; during CHECK/RESP keep valid high with a would-be-unlock to prove it is ignored
    task automatic do_req(input int ch, input bit op, input logic [15:0] key);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_ch    = 2'(ch);
        req_op    = op;
        req_key   = key;
        e.cyc     = cyc + 3;
        model(ch, op, key, e.st);
        e.lk = m_locked;
        e.lo = m_lockout;
        exp_q.push_back(e);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("req_ready_busy", 32'(req_ready), 0);
            req_ch  = 2'($urandom_range(0, 3));
            req_op  = 1'b0;
            req_key = KEY;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_locked", 32'(locked), 32'hF);
        chk("rst_lockout", 32'(lockout), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_status", 32'(rsp_status), 0);
        chk("rst_d3_locked", 32'(d3_locked), 32'h7);
    endtask

    task automatic do_reset();
        idle(3);
        d3_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", 32'(req_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values();
        model_reset();
    endtask

    // Reset hits the transaction in CHECK (d=1) or RESP (d=2)
    task automatic abort_req(input int d);
        idle(3);
        req_valid = 1'b1;
        req_ch    = 2'd3;
        req_op    = 1'b0;
        req_key   = KEY;
        @(negedge clk);
        req_valid = 1'b0;
        if (d == 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_in_reset", 32'(req_ready), 0);
        chk("abort_no_rsp", 32'(rsp_valid), 0);
        reset = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        idle(4);
    endtask

    task automatic d3_req(input int ch, input logic [15:0] key, input logic [1:0] est, input logic [2:0] elk);
        int w = 0;
        @(negedge clk);
        d3_valid = 1'b1;
        d3_ch    = 2'(ch);
        d3_op    = 1'b0;
        d3_key   = key;
        @(negedge clk);
        d3_valid = 1'b0;
        while (d3_rsp_valid !== 1'b1 && w < 6) begin
            @(negedge clk);
            w++;
        end
        chk("d3_rsp_valid", 32'(d3_rsp_valid), 1);
        chk("d3_latency", w, 2);
        chk("d3_status", 32'(d3_rsp_status), 32'(est));
        chk("d3_locked", 32'(d3_locked), 32'(elk));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] k;
        reset = 1'b1;
        req_valid = 1'b0; req_ch = '0; req_op = 1'b0; req_key = '0;
        d3_valid = 1'b0; d3_ch = '0; d3_op = 1'b0; d3_key = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(req_ready), 0);
        reset = 1'b0;
        #1;
        check_reset_values();
        idle(4);

        do_req(2, 0, KEY);
        repeat (3) do_req(1, 0, 16'h0000);
        do_req(1, 0, KEY);
        do_req(0, 0, 16'h1234);
        do_req(0, 0, 16'hFFFF);
        do_req(0, 0, KEY);
        do_req(0, 0, 16'h0000);
        do_req(0, 0, 16'h0001);
        do_req(2, 1, 16'h0000);
        do_req(2, 0, KEY);
        do_req(1, 1, KEY);
        do_req(1, 0, KEY);
        idle(3);

        abort_req(1);
        abort_req(2);

        d3_req(3, KEY, 2'd3, 3'b111);
        d3_req(2, KEY, 2'd0, 3'b011);
        do_reset();

        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 49) do_reset();
            k = ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom);
            do_req($urandom_range(0, 3), ($urandom_range(0, 3) == 0), k);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
